// File: rtl/lif_single_dualleak.sv
// lif_single_dualleak
// -------------------
// A single leaky-integrate-and-fire neuron behind the Tiny Tapeout user wrapper.
// Each enabled cycle, the 8-bit input current is added to a 12-bit membrane
// potential V. V also leaks by a right-shift of itself. The slow shift S applies
// below the knee voltage and the fast shift F applies at or above it. When the
// new potential reaches threshold, the neuron does three things: it emits a
// one-cycle spike, it clears V, and it starts a refractory countdown. During
// that countdown the input is ignored.
//
// Ports
//   clk      rising-edge clock for all state
//   rst_n    synchronous reset, active HIGH despite its name
//   ena      enable; 0 holds V and the refractory counter and forces spike to 0
//   ui_in    input current I (unsigned)
//   uio_in   [2:0] slow leak shift S, [5:3] fast leak shift F, [7:6] unused
//   uio_out  constant 0
//   uio_oe   constant 0 (all uio pins are inputs)
//   uo_out   [7] spike, [6] refractory flag, [5:0] V[11:6]
//
// Every output comes from a register or a constant. No input reaches an output
// combinationally.
module lif_single_dualleak #(
  parameter int V_W    = 12,
  parameter int THRESH = 2048,
  parameter int KNEE   = 1024,
  parameter int REFRAC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  // The refractory counter needs at least one bit, even when REFRAC is 0 or 1.
  localparam int R_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

  localparam logic [V_W-1:0] KNEE_V   = V_W'(KNEE);
  localparam logic [V_W:0]   THRESH_S = (V_W + 1)'(THRESH);
  localparam logic [R_W-1:0] REFRAC_R = R_W'(REFRAC);
  localparam logic [V_W-1:0] V_MAX    = {V_W{1'b1}};

  logic [V_W-1:0] v_q;
  logic [R_W-1:0] r_q;
  logic           spike_q;

  logic [2:0]     slow_shift;
  logic [2:0]     fast_shift;
  logic [V_W-1:0] leak;
  logic [V_W:0]   sum_wide;
  logic [V_W-1:0] sum_sat;
  logic           fire;

  assign slow_shift = uio_in[2:0];
  assign fast_shift = uio_in[5:3];

  // The leak region is chosen from the current V, not from the new sum.
  // A shift code of 0 turns that region's leak off.
  always_comb begin
    leak = '0;
    if (v_q >= KNEE_V) begin
      if (fast_shift != 3'd0) leak = v_q >> fast_shift;
    end else begin
      if (slow_shift != 3'd0) leak = v_q >> slow_shift;
    end
  end

  // Because leak <= V, the subtraction cannot underflow. The extra top bit
  // catches an overflow from adding the input, and an overflow saturates.
  always_comb begin
    sum_wide = {1'b0, v_q - leak} + {{(V_W - 7){1'b0}}, ui_in};
    sum_sat  = sum_wide[V_W] ? V_MAX : sum_wide[V_W-1:0];
    fire     = ({1'b0, sum_sat} >= THRESH_S);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      v_q     <= '0;
      r_q     <= '0;
      spike_q <= 1'b0;
    end else if (!ena) begin
      spike_q <= 1'b0;
    end else if (r_q != '0) begin
      // Refractory: the potential is pinned at 0 and the input is ignored.
      v_q     <= '0;
      r_q     <= r_q - 1'b1;
      spike_q <= 1'b0;
    end else if (fire) begin
      v_q     <= '0;
      r_q     <= REFRAC_R;
      spike_q <= 1'b1;
    end else begin
      v_q     <= sum_sat;
      spike_q <= 1'b0;
    end
  end

  assign uo_out  = {spike_q, (r_q != '0), v_q[V_W-1:V_W-6]};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_lif_single_dualleak.sv
// tb_lif_single_dualleak
// ----------------------
// Directed bench for lif_single_dualleak. Every expected uo_out value below was
// worked out by hand from the neuron's arithmetic, as {spike, refr, V>>6}.
module tb_lif_single_dualleak;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks   = 0;
  int failures = 0;

  lif_single_dualleak dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'd255;
    uio_in = 8'h00;
    repeat (cycles) step();
    rst_n = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive the inputs, take one edge, and check uo_out.
  task automatic drive_check(input string tag, input logic [7:0] cur,
                             input logic [7:0] leak_cfg, input logic [7:0] exp);
    ui_in  = cur;
    uio_in = leak_cfg;
    step();
    check(tag, uo_out, exp);
  endtask

  // Expected V>>6 for V = 200, 400, ..., 2000.
  logic [7:0] ramp_exp [10] = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd15,
                                8'd18, 8'd21, 8'd25, 8'd28, 8'd31};
  logic [7:0] slow_exp [4]  = '{8'd3, 8'd2, 8'd1, 8'd1};     // 192,144,108,81
  logic [7:0] fast_exp [5]  = '{8'd3, 8'd7, 8'd11, 8'd15, 8'd19};

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'd0;
    uio_in = 8'h00;

    // ---- reset ----
    do_reset(2);
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);

    // ---- integrate and fire, no leak ----
    for (int i = 0; i < 10; i++) drive_check($sformatf("ramp_%0d", i), 8'd200, 8'h00, ramp_exp[i]);
    drive_check("fire_spike", 8'd200, 8'h00, 8'hC0);

    // ---- refractory: three more flagged cycles, then clear ----
    for (int i = 0; i < 3; i++) drive_check($sformatf("refr_%0d", i), 8'd200, 8'h00, 8'h40);
    drive_check("refr_end", 8'd200, 8'h00, 8'h00);
    drive_check("post_refr_200", 8'd200, 8'h00, 8'h03);
    drive_check("post_refr_400", 8'd200, 8'h00, 8'h06);

    // ---- slow leak S=2 ----
    do_reset(1);
    drive_check("slow_load", 8'd255, 8'h00, 8'h03);
    for (int i = 0; i < 4; i++) drive_check($sformatf("slow_%0d", i), 8'd0, 8'h02, slow_exp[i]);

    // ---- fast leak F=1 above the knee, S=0 below ----
    do_reset(1);
    for (int i = 0; i < 5; i++) drive_check($sformatf("fast_load_%0d", i), 8'd255, 8'h00, fast_exp[i]);
    drive_check("fast_leak", 8'd0, 8'h08, 8'h09);          // 1275 - 637 = 638
    drive_check("fast_hold", 8'd0, 8'h08, 8'h09);          // below knee, S=0

    // ---- enable gating ----
    do_reset(1);
    for (int i = 0; i < 3; i++) drive_check($sformatf("gate_load_%0d", i), 8'd200, 8'h00, ramp_exp[i]);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) drive_check($sformatf("gate_hold_%0d", i), 8'd255, 8'h00, 8'h09);
    ena = 1'b1;
    drive_check("gate_resume", 8'd255, 8'h00, 8'h0D);      // 600 + 255 = 855

    // ---- reset during refractory clears the counter ----
    do_reset(1);
    for (int i = 0; i < 8; i++) step();                    // V = 2040
    check("pre_fire_255", uo_out, 8'h1F);
    step();                                                // 2295 -> fire
    check("fire_255", uo_out, 8'hC0);
    rst_n = 1'b1;
    step();
    check("reset_mid_refr", uo_out, 8'h00);
    rst_n = 1'b0;
    drive_check("after_reset_refr", 8'd255, 8'h00, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
